accumulator_reg: RTL and testbench

Parametrised accumulator register for the datapath: holds the working operand, loads from the shared data bus or from the ALU result, drives the ALU operand input continuously, and places its value on the bus through a registered, one-cycle-valid send. It adds shift operations, status flags and an optional save stack. One opcode executes per clock; all state changes occur on the rising edge.

---
 rtl/accumulator_reg_if.sv | 28 ++
 rtl/accumulator_reg.sv | 135 +++++++++++++
 tb/tb_accumulator_reg.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/accumulator_reg_if.sv
// rtl/accumulator_reg_if.sv - opcode, bus and status signals between datapath control and the accumulator
// master drives op/data; slave is the accumulator register.
interface accumulator_reg_if #(
  parameter int WIDTH = 8
);
  logic [2:0]       op;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] alu_in;
  logic [WIDTH-1:0] alu_out;
  logic [WIDTH-1:0] bus_out;
  logic             bus_valid;
  logic             zero;
  logic             neg;
  logic             carry;
  logic             stk_full;
  logic             stk_empty;
  logic             stk_err;

  modport master (
    output op, data_in, alu_in,
    input  alu_out, bus_out, bus_valid, zero, neg, carry, stk_full, stk_empty, stk_err
  );

  modport slave (
    input  op, data_in, alu_in,
    output alu_out, bus_out, bus_valid, zero, neg, carry, stk_full, stk_empty, stk_err
  );
endinterface

// File: rtl/accumulator_reg.sv
// rtl/accumulator_reg.sv - accumulator with load, shift, registered send and status flags
// Optional LIFO save stack enabled by defining ACC_STACK_EN.
module accumulator_reg #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  accumulator_reg_if.slave  bus
);
  typedef enum logic [2:0] {
    OP_NOP      = 3'd0,
    OP_LOAD     = 3'd1,
    OP_LOAD_ALU = 3'd2,
    OP_SEND     = 3'd3,
    OP_SHL      = 3'd4,
    OP_SHR      = 3'd5,
    OP_PUSH     = 3'd6,
    OP_POP      = 3'd7
  } op_e;

  op_e              op;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] bus_out_q, bus_out_d;
  logic             carry_q, carry_d;
  logic             bus_valid_q, bus_valid_d;
  logic             pop_ok;
  logic [WIDTH-1:0] pop_data;

  assign op = op_e'(bus.op);

  always_comb begin
    acc_d       = acc_q;
    carry_d     = carry_q;
    bus_out_d   = bus_out_q;
    bus_valid_d = 1'b0;
    case (op)
      OP_LOAD:     acc_d = bus.data_in;
      OP_LOAD_ALU: acc_d = bus.alu_in;
      OP_SEND: begin
        bus_out_d   = acc_q;
        bus_valid_d = 1'b1;
      end
      OP_SHL: begin
        carry_d = acc_q[WIDTH-1];
        acc_d   = {acc_q[WIDTH-2:0], 1'b0};
      end
      OP_SHR: begin
        carry_d = acc_q[0];
        acc_d   = {1'b0, acc_q[WIDTH-1:1]};
      end
      OP_POP: if (pop_ok) acc_d = pop_data;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q       <= '0;
      carry_q     <= 1'b0;
      bus_out_q   <= '0;
      bus_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      carry_q     <= carry_d;
      bus_out_q   <= bus_out_d;
      bus_valid_q <= bus_valid_d;
    end
  end

`ifdef ACC_STACK_EN
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] stack_q [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             stk_err_q, stk_err_d;
  logic             full, empty, push_ok;
  logic [AW-1:0]    push_idx, pop_idx;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign push_ok  = (op == OP_PUSH) && !full;
  assign pop_ok   = (op == OP_POP) && !empty;
  assign push_idx = AW'(count_q);
  assign pop_idx  = AW'(count_q - CW'(1));
  assign pop_data = stack_q[pop_idx];

  always_comb begin
    count_d   = count_q;
    stk_err_d = 1'b0;
    if (push_ok)
      count_d = count_q + CW'(1);
    else if (pop_ok)
      count_d = count_q - CW'(1);
    else if ((op == OP_PUSH) || (op == OP_POP))
      stk_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q   <= '0;
      stk_err_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      stk_err_q <= stk_err_d;
    end
  end

  // Entries above count are don't-care, so storage needs no reset.
  always_ff @(posedge clk) begin
    if (push_ok)
      stack_q[push_idx] <= acc_q;
  end

  assign bus.stk_full  = full;
  assign bus.stk_empty = empty;
  assign bus.stk_err   = stk_err_q;
`else
  wire unused_depth = (DEPTH > 0);

  assign pop_ok        = 1'b0;
  assign pop_data      = '0;
  assign bus.stk_full  = 1'b0;
  assign bus.stk_empty = 1'b1;
  assign bus.stk_err   = 1'b0;
`endif

  assign bus.alu_out   = acc_q;
  assign bus.bus_out   = bus_out_q;
  assign bus.bus_valid = bus_valid_q;
  assign bus.carry     = carry_q;
  assign bus.zero      = (acc_q == '0);
  assign bus.neg       = acc_q[WIDTH-1];
endmodule

// File: tb/tb_accumulator_reg.sv
// tb/tb_accumulator_reg.sv - directed self-checking bench for accumulator_reg
// Stack expectations follow ACC_STACK_EN.
module tb_accumulator_reg;
  logic clk;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  accumulator_reg_if #(.WIDTH(8)) bus ();

  accumulator_reg #(.WIDTH(8), .DEPTH(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [2:0] o, input logic [7:0] d, input logic [7:0] a);
    bus.op      = o;
    bus.data_in = d;
    bus.alu_in  = a;
    @(posedge clk);
    #1;
    bus.op = 3'd0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_acc"},   32'(bus.alu_out), 32'h00);
    chk({tag, "_zero"},  32'(bus.zero), 32'd1);
    chk({tag, "_neg"},   32'(bus.neg), 32'd0);
    chk({tag, "_carry"}, 32'(bus.carry), 32'd0);
    chk({tag, "_bout"},  32'(bus.bus_out), 32'h00);
    chk({tag, "_bval"},  32'(bus.bus_valid), 32'd0);
    chk({tag, "_full"},  32'(bus.stk_full), 32'd0);
    chk({tag, "_empty"}, 32'(bus.stk_empty), 32'd1);
    chk({tag, "_err"},   32'(bus.stk_err), 32'd0);
  endtask

  localparam logic [2:0] NOP = 3'd0, LOAD = 3'd1, LDALU = 3'd2, SEND = 3'd3;
  localparam logic [2:0] SHL = 3'd4, SHR = 3'd5, PUSH = 3'd6, POP = 3'd7;

  initial begin
    bus.op      = NOP;
    bus.data_in = '0;
    bus.alu_in  = '0;
    reset_n     = 1'b0;
    #12;
    chk_reset_state("rst");
    @(negedge clk);
    reset_n = 1'b1;

    // load and single send
    do_op(LOAD, 8'h0C, 8'h00);
    chk("load_acc", 32'(bus.alu_out), 32'h0C);
    chk("load_zero", 32'(bus.zero), 32'd0);
    chk("load_neg", 32'(bus.neg), 32'd0);
    chk("load_bval", 32'(bus.bus_valid), 32'd0);
    do_op(SEND, 8'h00, 8'h00);
    chk("send_bout", 32'(bus.bus_out), 32'h0C);
    chk("send_bval", 32'(bus.bus_valid), 32'd1);
    do_op(NOP, 8'h00, 8'h00);
    chk("send_bval_drop", 32'(bus.bus_valid), 32'd0);
    chk("send_bout_hold", 32'(bus.bus_out), 32'h0C);

    // shifts and carry
    do_op(LOAD, 8'h81, 8'h00);
    do_op(SHL, 8'h00, 8'h00);
    chk("shl_acc", 32'(bus.alu_out), 32'h02);
    chk("shl_carry", 32'(bus.carry), 32'd1);
    do_op(SHR, 8'h00, 8'h00);
    chk("shr_acc", 32'(bus.alu_out), 32'h01);
    chk("shr_carry", 32'(bus.carry), 32'd0);
    do_op(LOAD, 8'h00, 8'h00);
    chk("ld0_zero", 32'(bus.zero), 32'd1);
    chk("ld0_carry", 32'(bus.carry), 32'd0);
    do_op(LOAD, 8'hC3, 8'h00);
    do_op(SHL, 8'h00, 8'h00);
    chk("shl2_acc", 32'(bus.alu_out), 32'h86);
    do_op(LOAD, 8'h33, 8'h00);
    chk("carry_hold_load", 32'(bus.carry), 32'd1);
    do_op(SHR, 8'h00, 8'h00);
    chk("shr2_acc", 32'(bus.alu_out), 32'h19);
    chk("shr2_carry", 32'(bus.carry), 32'd1);

    // load from ALU, back-to-back sends
    do_op(LDALU, 8'h11, 8'hF0);
    chk("ldalu_acc", 32'(bus.alu_out), 32'hF0);
    chk("ldalu_neg", 32'(bus.neg), 32'd1);
    for (int i = 0; i < 3; i++) begin
      do_op(SEND, 8'h00, 8'h00);
      chk($sformatf("send3_bval%0d", i), 32'(bus.bus_valid), 32'd1);
      chk($sformatf("send3_bout%0d", i), 32'(bus.bus_out), 32'hF0);
    end
    do_op(NOP, 8'h00, 8'h00);
    chk("send3_drop", 32'(bus.bus_valid), 32'd0);

`ifdef ACC_STACK_EN
    for (int i = 1; i <= 4; i++) begin
      do_op(LOAD, 8'(i), 8'h00);
      do_op(PUSH, 8'h00, 8'h00);
      chk($sformatf("push%0d_err", i), 32'(bus.stk_err), 32'd0);
      chk($sformatf("push%0d_empty", i), 32'(bus.stk_empty), 32'd0);
    end
    chk("push_full", 32'(bus.stk_full), 32'd1);
    do_op(PUSH, 8'h00, 8'h00);
    chk("ovf_err", 32'(bus.stk_err), 32'd1);
    chk("ovf_full", 32'(bus.stk_full), 32'd1);
    do_op(NOP, 8'h00, 8'h00);
    chk("ovf_err_drop", 32'(bus.stk_err), 32'd0);
    do_op(LOAD, 8'hEE, 8'h00);
    for (int i = 4; i >= 1; i--) begin
      do_op(POP, 8'h00, 8'h00);
      chk($sformatf("pop%0d_acc", i), 32'(bus.alu_out), 32'(i));
      chk($sformatf("pop%0d_err", i), 32'(bus.stk_err), 32'd0);
      chk($sformatf("pop%0d_full", i), 32'(bus.stk_full), 32'd0);
    end
    chk("pop_empty", 32'(bus.stk_empty), 32'd1);
    do_op(POP, 8'h00, 8'h00);
    chk("udf_err", 32'(bus.stk_err), 32'd1);
    chk("udf_acc", 32'(bus.alu_out), 32'h01);
    do_op(NOP, 8'h00, 8'h00);
    chk("udf_err_drop", 32'(bus.stk_err), 32'd0);
`else
    do_op(LOAD, 8'h5A, 8'h00);
    do_op(PUSH, 8'h00, 8'h00);
    chk("nostk_push_acc", 32'(bus.alu_out), 32'h5A);
    chk("nostk_push_err", 32'(bus.stk_err), 32'd0);
    chk("nostk_push_empty", 32'(bus.stk_empty), 32'd1);
    chk("nostk_push_full", 32'(bus.stk_full), 32'd0);
    do_op(LOAD, 8'h00, 8'h00);
    do_op(LOAD, 8'h5A, 8'h00);
    do_op(POP, 8'h00, 8'h00);
    chk("nostk_pop_acc", 32'(bus.alu_out), 32'h5A);
    chk("nostk_pop_err", 32'(bus.stk_err), 32'd0);
    chk("nostk_pop_empty", 32'(bus.stk_empty), 32'd1);
`endif

    // asynchronous reset mid-operation
    do_op(LOAD, 8'h77, 8'h00);
    do_op(PUSH, 8'h00, 8'h00);
    do_op(PUSH, 8'h00, 8'h00);
    do_op(SHR, 8'h00, 8'h00);
    do_op(SEND, 8'h00, 8'h00);
    chk("pre_rst_bval", 32'(bus.bus_valid), 32'd1);
    chk("pre_rst_bout", 32'(bus.bus_out), 32'h3B);
    chk("pre_rst_carry", 32'(bus.carry), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_state("arst");
    reset_n = 1'b1;
    do_op(POP, 8'h00, 8'h00);
`ifdef ACC_STACK_EN
    chk("post_rst_pop_err", 32'(bus.stk_err), 32'd1);
`else
    chk("post_rst_pop_err", 32'(bus.stk_err), 32'd0);
`endif
    chk("post_rst_pop_acc", 32'(bus.alu_out), 32'h00);
    chk("post_rst_empty", 32'(bus.stk_empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
